// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mm:ss stopwatch sequencer with run/pause/clear/adjust and adjust-mode blink mask.
// Optional lap freeze is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
    parameter int MAX_MIN = 59
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_4hz,
    input  logic       btn_pause,
    input  logic       btn_clear,
    input  logic       btn_lap,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] blink_mask,
    output logic [1:0] state,
    output logic       lap_active
);

    typedef enum logic [1:0] {
        PAUSED  = 2'd0,
        RUNNING = 2'd1,
        ADJUST  = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
    } bcd_time_t;

    localparam logic [3:0] MAX_MT = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_MO = 4'(MAX_MIN % 10);

    state_t    cur, nxt_state;
    bcd_time_t live, live_n;
    logic      phase, phase_n;
    logic [3:0] mask_q, mask_n;
    logic [8:0] sec_inc;
    logic [7:0] min_inc;

    // Returns {carry, tens, ones}; carry marks the 59 -> 00 rollover.
    function automatic logic [8:0] inc_sec(input logic [3:0] tens, input logic [3:0] ones);
        if (ones == 4'd9) begin
            if (tens == 4'd5) return {1'b1, 8'h00};
            return {1'b0, tens + 4'd1, 4'd0};
        end
        return {1'b0, tens, ones + 4'd1};
    endfunction

    function automatic logic [7:0] inc_min(input logic [3:0] tens, input logic [3:0] ones);
        if (tens == MAX_MT && ones == MAX_MO) return 8'h00;
        if (ones == 4'd9) return {tens + 4'd1, 4'd0};
        return {tens, ones + 4'd1};
    endfunction

    always_comb begin
        nxt_state = cur;
        live_n    = live;
        phase_n   = phase;
        mask_n    = 4'b0000;
        sec_inc   = inc_sec(live.st, live.so);
        min_inc   = inc_min(live.mt, live.mo);

        if (sw_adj)                nxt_state = ADJUST;
        else if (cur == ADJUST)    nxt_state = PAUSED;
        else if (btn_clear)        nxt_state = PAUSED;
        else if (btn_pause)        nxt_state = (cur == RUNNING) ? PAUSED : RUNNING;

        // Clear outranks every tick, so a simultaneous tick is simply dropped.
        if (btn_clear) begin
            live_n = '0;
        end else if (cur == RUNNING && tick_1hz) begin
            {live_n.st, live_n.so} = sec_inc[7:0];
            if (sec_inc[8]) {live_n.mt, live_n.mo} = min_inc;
        end else if (cur == ADJUST && tick_2hz) begin
            if (sw_sel) {live_n.st, live_n.so} = sec_inc[7:0];
            else        {live_n.mt, live_n.mo} = min_inc;
        end

        if (nxt_state != ADJUST || cur != ADJUST) phase_n = 1'b0;
        else if (tick_4hz)                        phase_n = ~phase;

        if (nxt_state == ADJUST && phase_n) mask_n = sw_sel ? 4'b0011 : 4'b1100;
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            cur    <= PAUSED;
            live   <= '0;
            phase  <= 1'b0;
            mask_q <= 4'b0000;
        end else begin
            cur    <= nxt_state;
            live   <= live_n;
            phase  <= phase_n;
            mask_q <= mask_n;
        end
    end

    assign state      = cur;
    assign blink_mask = mask_q;

`ifdef STOPWATCH_LAP_EN
    logic      lap_q, lap_n;
    bcd_time_t snap, snap_n;
    bcd_time_t disp;

    always_comb begin
        lap_n  = lap_q;
        snap_n = snap;
        if (nxt_state == ADJUST || btn_clear || btn_pause) lap_n = 1'b0;
        else if (btn_lap && cur == RUNNING)                lap_n = ~lap_q;
        if (lap_n && !lap_q) snap_n = live_n;
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            lap_q <= 1'b0;
            snap  <= '0;
            disp  <= '0;
        end else begin
            lap_q <= lap_n;
            snap  <= snap_n;
            disp  <= lap_n ? snap_n : live_n;
        end
    end

    assign lap_active = lap_q;
    assign {min_tens, min_ones, sec_tens, sec_ones} = disp;
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign lap_active = 1'b0;
    assign {min_tens, min_ones, sec_tens, sec_ones} = live;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl (default MAX_MIN = 59).
module tb_stopwatch_ctrl;

    logic       clk_100mhz = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0, tick_2hz = 1'b0, tick_4hz = 1'b0;
    logic       btn_pause = 1'b0, btn_clear = 1'b0, btn_lap = 1'b0;
    logic       sw_adj = 1'b0, sw_sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blink_mask;
    logic [1:0] state;
    logic       lap_active;

    int total = 0;
    int bad   = 0;

    stopwatch_ctrl #(.MAX_MIN(59)) dut (
        .clk_100mhz(clk_100mhz),
        .rst_n(rst_n),
        .tick_1hz(tick_1hz),
        .tick_2hz(tick_2hz),
        .tick_4hz(tick_4hz),
        .btn_pause(btn_pause),
        .btn_clear(btn_clear),
        .btn_lap(btn_lap),
        .sw_adj(sw_adj),
        .sw_sel(sw_sel),
        .min_tens(min_tens),
        .min_ones(min_ones),
        .sec_tens(sec_tens),
        .sec_ones(sec_ones),
        .blink_mask(blink_mask),
        .state(state),
        .lap_active(lap_active)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    task automatic step();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag, input logic [15:0] exp);
        check(tag, {min_tens, min_ones, sec_tens, sec_ones}, exp);
    endtask

    task automatic tick1(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1; step(); tick_1hz = 1'b0; step();
        end
    endtask

    task automatic tick2(input int n);
        for (int i = 0; i < n; i++) begin
            tick_2hz = 1'b1; step(); tick_2hz = 1'b0; step();
        end
    endtask

    task automatic pulse_pause();
        btn_pause = 1'b1; step(); btn_pause = 1'b0;
    endtask

    task automatic pulse_lap();
        btn_lap = 1'b1; step(); btn_lap = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("reset_time", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
        check("reset_state", 16'(state), 16'd0);
        check("reset_mask", 16'(blink_mask), 16'h0);
        check("reset_lap", 16'(lap_active), 16'd0);
        rst_n = 1'b1;
        step();

        // Ticks in PAUSED are ignored
        tick1(2);
        check_time("paused_hold", 16'h0000);

        // Run 65 seconds -> 01:05
        pulse_pause();
        check("run_state", 16'(state), 16'd1);
        tick1(65);
        check_time("run_65", 16'h0105);

        // Preload 59:59 via adjust, then wrap
        sw_adj = 1'b1; sw_sel = 1'b0; step();
        check("adj_enter_state", 16'(state), 16'd2);
        check("adj_enter_mask", 16'(blink_mask), 16'h0);
        tick2(58);
        sw_sel = 1'b1;
        tick2(54);
        check_time("preload_5959", 16'h5959);
        sw_adj = 1'b0; step();
        check("adj_exit_state", 16'(state), 16'd0);
        pulse_pause();
        tick1(1);
        check_time("full_wrap", 16'h0000);
        check("wrap_state", 16'(state), 16'd1);

        // Pause+clear together at 00:10
        tick1(10);
        check_time("run_10", 16'h0010);
        btn_pause = 1'b1; btn_clear = 1'b1; step();
        btn_pause = 1'b0; btn_clear = 1'b0;
        check("clr_pause_state", 16'(state), 16'd0);
        check_time("clr_pause_time", 16'h0000);
        tick1(1);
        check_time("clr_then_tick", 16'h0000);

        // Clear in the same cycle as a tick while running
        pulse_pause();
        tick1(3);
        btn_clear = 1'b1; tick_1hz = 1'b1; step();
        btn_clear = 1'b0; tick_1hz = 1'b0;
        check_time("clr_tick_time", 16'h0000);
        check("clr_tick_state", 16'(state), 16'd0);

        // Adjust seconds from 00:58 without carry
        sw_adj = 1'b1; sw_sel = 1'b1; step();
        tick2(58);
        check_time("adj_sec_58", 16'h0058);
        tick2(3);
        check_time("adj_sec_wrap", 16'h0001);
        tick_4hz = 1'b1; step(); tick_4hz = 1'b0;
        check("blink_sec", 16'(blink_mask), 16'h3);
        sw_sel = 1'b0; step();
        check("blink_min", 16'(blink_mask), 16'hC);
        tick_4hz = 1'b1; step(); tick_4hz = 1'b0;
        check("blink_off", 16'(blink_mask), 16'h0);
        tick_4hz = 1'b1; step(); tick_4hz = 1'b0;
        check("blink_on_again", 16'(blink_mask), 16'hC);
        btn_clear = 1'b1; step(); btn_clear = 1'b0;
        check_time("adj_clear_time", 16'h0000);
        check("adj_clear_state", 16'(state), 16'd2);
        sw_adj = 1'b0; step();
        check("adj_drop_state", 16'(state), 16'd0);
        check("adj_drop_mask", 16'(blink_mask), 16'h0);

        // Minutes adjust wraps MAX_MIN -> 00 without touching seconds
        sw_adj = 1'b1; sw_sel = 1'b0; step();
        tick2(60);
        check_time("adj_min_wrap", 16'h0000);

        // Preload 12:34, run, then async reset between edges
        tick2(12);
        sw_sel = 1'b1;
        tick2(34);
        sw_adj = 1'b0; step();
        pulse_pause();
        check_time("preload_1234", 16'h1234);
        check("preload_state", 16'(state), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check_time("async_rst_time", 16'h0000);
        check("async_rst_state", 16'(state), 16'd0);
        check("async_rst_mask", 16'(blink_mask), 16'h0);
        rst_n = 1'b1;
        step();

        // Lap freeze (live display when the feature is not built)
        pulse_pause();
        tick1(3);
        check_time("lap_pre", 16'h0003);
        pulse_lap();
`ifdef STOPWATCH_LAP_EN
        check("lap_on", 16'(lap_active), 16'd1);
`else
        check("lap_on", 16'(lap_active), 16'd0);
`endif
        tick1(4);
`ifdef STOPWATCH_LAP_EN
        check_time("lap_frozen", 16'h0003);
`else
        check_time("lap_frozen", 16'h0007);
`endif
        pulse_lap();
        check_time("lap_release", 16'h0007);
        check("lap_off", 16'(lap_active), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
